// File: rtl/pipeline_chain_pkg.sv
// ============================================================================
// Module      : pipeline_chain_pkg
// Description : Shared defaults, the NOP bubble constant and the per-stage
//               register select encoding for the pipeline chain.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipeline_chain_pkg;

    localparam int          DEF_DATA_W = 32;
    localparam int          DEF_DEPTH  = 4;
    localparam int          DEF_CNT_W  = 32;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    typedef enum logic [1:0] {
        SEL_LOAD   = 2'd0,
        SEL_HOLD   = 2'd1,
        SEL_BUBBLE = 2'd2
    } stage_sel_e;

    // An invalid slot always carries the bubble payload, even when held.
    function automatic stage_sel_e stage_sel(input logic hold, input logic next_valid);
        stage_sel_e sel;
        if (!next_valid) begin
            sel = SEL_BUBBLE;
        end else if (hold) begin
            sel = SEL_HOLD;
        end else begin
            sel = SEL_LOAD;
        end
        return sel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// ============================================================================
// Module      : pipe_stage_reg
// Description : One pipeline slot: valid bit plus payload with hold/load/bubble.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_reg
    import pipeline_chain_pkg::*;
#(
    parameter int                DATA_W      = DEF_DATA_W,
    parameter logic [DATA_W-1:0] BUBBLE_DATA = DATA_W'(NOP_INSTR)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              hold_i,
    input  logic              keep_valid_i,
    input  logic              load_valid_i,
    input  logic [DATA_W-1:0] load_data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q;
    logic              valid_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;
    stage_sel_e        sel;

    always_comb begin
        valid_d = hold_i ? keep_valid_i : load_valid_i;
        sel     = stage_sel(hold_i, valid_d);
        case (sel)
            SEL_HOLD: data_d = data_q;
            SEL_LOAD: data_d = load_data_i;
            default:  data_d = BUBBLE_DATA;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            valid_q <= 1'b0;
            data_q  <= BUBBLE_DATA;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

`default_nettype wire

// File: rtl/pipeline_chain.sv
// ============================================================================
// Module      : pipeline_chain
// Description : DEPTH-stage in-order pipeline with per-stage stall/flush,
//               occupancy and saturating stall/bubble performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_chain
    import pipeline_chain_pkg::*;
#(
    parameter int                DATA_W      = DEF_DATA_W,
    parameter int                DEPTH       = DEF_DEPTH,
    parameter logic [DATA_W-1:0] BUBBLE_DATA = DATA_W'(NOP_INSTR),
    parameter int                CNT_W       = DEF_CNT_W
) (
    input  logic                       CLK,
    input  logic                       RESET_N,
    input  logic                       IN_VALID,
    input  logic [DATA_W-1:0]          IN_DATA,
    output logic                       IN_READY,
    input  logic [DEPTH-1:0]           STALL,
    input  logic [DEPTH-1:0]           FLUSH,
    output logic [DEPTH-1:0]           STAGE_VALID,
    output logic [DEPTH*DATA_W-1:0]    STAGE_DATA,
    output logic [$clog2(DEPTH+1)-1:0] OCCUPANCY,
    output logic [CNT_W-1:0]           STALL_CNT,
    output logic [CNT_W-1:0]           BUBBLE_CNT
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]  hold;
    logic [DEPTH-1:0]  eff;
    logic [DEPTH-1:0]  ld_valid;
    logic [DATA_W-1:0] ld_data [DEPTH];
    logic [DATA_W-1:0] st_data [DEPTH];
    logic [OCC_W-1:0]  occ;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  bubble_cnt_q;

    assign eff      = STAGE_VALID & ~FLUSH;
    assign IN_READY = ~hold[0];

    // A stall at stage i freezes i and everything younger (lower index).
    for (genvar i = 0; i < DEPTH; i++) begin : g_hold
        assign hold[i] = |STALL[DEPTH-1:i];
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_first
            assign ld_valid[i] = IN_VALID;
            assign ld_data[i]  = IN_DATA;
        end else begin : g_rest
            // Upstream held while this stage moves on: a bubble enters.
            assign ld_valid[i] = eff[i-1] & ~hold[i-1];
            assign ld_data[i]  = st_data[i-1];
        end

        pipe_stage_reg #(
            .DATA_W      (DATA_W),
            .BUBBLE_DATA (BUBBLE_DATA)
        ) u_stage (
            .clk_i        (CLK),
            .rst_n_i      (RESET_N),
            .hold_i       (hold[i]),
            .keep_valid_i (eff[i]),
            .load_valid_i (ld_valid[i]),
            .load_data_i  (ld_data[i]),
            .valid_o      (STAGE_VALID[i]),
            .data_o       (st_data[i])
        );

        assign STAGE_DATA[i*DATA_W +: DATA_W] = st_data[i];
    end

    always_comb begin
        occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ = occ + OCC_W'(STAGE_VALID[i]);
        end
    end

    assign OCCUPANCY = occ;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (!IN_READY && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (!STAGE_VALID[DEPTH-1] && (bubble_cnt_q != '1)) begin
                bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
            end
        end
    end

    assign STALL_CNT  = stall_cnt_q;
    assign BUBBLE_CNT = bubble_cnt_q;

endmodule

`default_nettype wire
